// File: rtl/tulip_prog_pkg.sv
// rtl/tulip_prog_pkg.sv - shared types and header field positions for the programming sequencer
package tulip_prog_pkg;

  // Programming target selected by header bits [31:30]
  typedef enum logic [1:0] {
    PROG_TGT_LUT     = 2'd0,
    PROG_TGT_USR_FIR = 2'd1,
    PROG_TGT_REVERB  = 2'd2,
    PROG_TGT_INVALID = 2'd3
  } prog_tgt_e;

  // Header field positions
  localparam int TGT_MSB = 31;
  localparam int TGT_LSB = 30;
  localparam int LEN_MSB = 15;

  // Sequencer states
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RST       = 3'd1,
    STREAM    = 3'd2,
    WAIT_DONE = 3'd3,
    DRAIN     = 3'd4
  } prog_state_e;

endpackage

// File: rtl/tulip_prog_sequencer_if.sv
// rtl/tulip_prog_sequencer_if.sv - programming input stream and the three target programming ports
interface tulip_prog_sequencer_if #(
  parameter int LUT_W = 24,
  parameter int TAP_W = 16
);

  logic [31:0]      prog_din;
  logic             prog_din_valid;
  logic             prog_din_ready;

  logic [LUT_W-1:0] lut_prog_din;
  logic             lut_prog_din_valid;
  logic             lut_prog_din_ready;
  logic             lut_prog_din_done;

  logic [TAP_W-1:0] usr_fir_taps_prog_din;
  logic             usr_fir_taps_prog_din_valid;
  logic             usr_fir_taps_prog_din_ready;
  logic             usr_fir_taps_prog_din_done;

  logic [TAP_W-1:0] reverb_taps_prog_din;
  logic             reverb_taps_prog_din_valid;
  logic             reverb_taps_prog_din_ready;
  logic             reverb_taps_prog_din_done;

  // Sequencer side: sinks the programming stream, sources the target ports
  modport master (
    input  prog_din, prog_din_valid,
    output prog_din_ready,
    output lut_prog_din, lut_prog_din_valid,
    input  lut_prog_din_ready, lut_prog_din_done,
    output usr_fir_taps_prog_din, usr_fir_taps_prog_din_valid,
    input  usr_fir_taps_prog_din_ready, usr_fir_taps_prog_din_done,
    output reverb_taps_prog_din, reverb_taps_prog_din_valid,
    input  reverb_taps_prog_din_ready, reverb_taps_prog_din_done
  );

  // Environment side: stream source plus the three targets
  modport slave (
    output prog_din, prog_din_valid,
    input  prog_din_ready,
    input  lut_prog_din, lut_prog_din_valid,
    output lut_prog_din_ready, lut_prog_din_done,
    input  usr_fir_taps_prog_din, usr_fir_taps_prog_din_valid,
    output usr_fir_taps_prog_din_ready, usr_fir_taps_prog_din_done,
    input  reverb_taps_prog_din, reverb_taps_prog_din_valid,
    output reverb_taps_prog_din_ready, reverb_taps_prog_din_done
  );

endinterface

// File: rtl/tulip_prog_sequencer.sv
// rtl/tulip_prog_sequencer.sv - routes header-framed coefficient packets to the tulip_dsp programming ports
module tulip_prog_sequencer
  import tulip_prog_pkg::*;
#(
  parameter int G_LUT_DWIDTH   = 24,
  parameter int G_TAP_DWIDTH   = 16,
  parameter int G_RESET_CYCLES = 4,
  parameter int G_DONE_TIMEOUT = 1024
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          abort,
  input  logic                          clear_errors,
  tulip_prog_sequencer_if.master        bus,
  output logic                          lut_tf_sw_resetn,
  output logic                          usr_fir_sw_resetn,
  output logic                          reverb_sw_resetn,
  output logic                          busy,
  output logic                          pkt_done,
  output logic                          err_bad_target,
  output logic                          err_overrun,
  output logic                          err_timeout
);

  localparam int TMAX = (G_DONE_TIMEOUT > G_RESET_CYCLES) ? G_DONE_TIMEOUT : G_RESET_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0] RST_LAST  = TW'(G_RESET_CYCLES - 1);
  localparam logic [TW-1:0] WAIT_LAST = TW'(G_DONE_TIMEOUT - 1);

  prog_state_e   state_q, state_d;
  prog_tgt_e     tgt_q, tgt_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          started_q, started_d;
  logic [2:0]    rstn_q, rstn_d;
  logic          pkt_done_q, pkt_done_d;
  logic          err_bad_q, err_bad_d;
  logic          err_ovr_q, err_ovr_d;
  logic          err_to_q, err_to_d;

  logic          din_ready;
  logic          fwd_valid;
  logic          sel_ready;
  logic          sel_done;
  logic          set_bad, set_ovr, set_to;
  prog_tgt_e     hdr_tgt;
  logic [15:0]   hdr_len;
  logic          unused_hdr_bits;

  assign hdr_tgt = prog_tgt_e'(bus.prog_din[TGT_MSB:TGT_LSB]);
  assign hdr_len = bus.prog_din[LEN_MSB:0];
  // Header bits [29:16] carry nothing for us
  assign unused_hdr_bits = ^bus.prog_din[29:16];

  // Ready/done of the currently latched target
  always_comb begin
    sel_ready = 1'b0;
    sel_done  = 1'b0;
    case (tgt_q)
      PROG_TGT_LUT: begin
        sel_ready = bus.lut_prog_din_ready;
        sel_done  = bus.lut_prog_din_done;
      end
      PROG_TGT_USR_FIR: begin
        sel_ready = bus.usr_fir_taps_prog_din_ready;
        sel_done  = bus.usr_fir_taps_prog_din_done;
      end
      PROG_TGT_REVERB: begin
        sel_ready = bus.reverb_taps_prog_din_ready;
        sel_done  = bus.reverb_taps_prog_din_done;
      end
      default: begin
        sel_ready = 1'b0;
        sel_done  = 1'b0;
      end
    endcase
  end

  // Next-state, counters, stream pass-through and error events
  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    cnt_d      = cnt_q;
    timer_d    = timer_q;
    started_d  = 1'b1;
    din_ready  = 1'b0;
    fwd_valid  = 1'b0;
    set_bad    = 1'b0;
    set_ovr    = 1'b0;
    set_to     = 1'b0;
    pkt_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        // Ready is held off for the first cycle out of reset
        din_ready = started_q;
        if (started_q && bus.prog_din_valid) begin
          tgt_d   = hdr_tgt;
          cnt_d   = hdr_len;
          timer_d = '0;
          if (hdr_tgt == PROG_TGT_INVALID) begin
            set_bad = 1'b1;
            state_d = DRAIN;
          end else begin
            state_d = RST;
          end
        end
      end

      RST: begin
        if (timer_q == RST_LAST) begin
          timer_d = '0;
          state_d = (cnt_q == 16'd0) ? WAIT_DONE : STREAM;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      STREAM: begin
        // Done with more than one word left stops the stream at once;
        // done alongside the final word still lets that word through
        if (sel_done && (cnt_q != 16'd1)) begin
          set_ovr = 1'b1;
          state_d = DRAIN;
        end else begin
          fwd_valid = bus.prog_din_valid;
          din_ready = sel_ready;
          if (bus.prog_din_valid && sel_ready) begin
            cnt_d = cnt_q - 16'd1;
            if (cnt_q == 16'd1) begin
              timer_d = '0;
              state_d = WAIT_DONE;
            end
          end else if (sel_done) begin
            set_ovr = 1'b1;
            state_d = DRAIN;
          end
        end
      end

      WAIT_DONE: begin
        if (sel_done) begin
          pkt_done_d = 1'b1;
          state_d    = IDLE;
        end else if (timer_q == WAIT_LAST) begin
          set_to  = 1'b1;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      DRAIN: begin
        din_ready = 1'b1;
        if (cnt_q == 16'd0) begin
          state_d = IDLE;
        end else if (bus.prog_din_valid) begin
          cnt_d = cnt_q - 16'd1;
          if (cnt_q == 16'd1) begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort overrides everything; ready also drops so no word is lost to it
    if (abort) begin
      state_d    = IDLE;
      cnt_d      = '0;
      timer_d    = '0;
      din_ready  = 1'b0;
      fwd_valid  = 1'b0;
      set_bad    = 1'b0;
      set_ovr    = 1'b0;
      set_to     = 1'b0;
      pkt_done_d = 1'b0;
    end
  end

  // Soft reset of the selected target is low exactly while the next state is RST
  always_comb begin
    rstn_d = 3'b111;
    if (state_d == RST) begin
      case (tgt_d)
        PROG_TGT_LUT:     rstn_d[0] = 1'b0;
        PROG_TGT_USR_FIR: rstn_d[1] = 1'b0;
        PROG_TGT_REVERB:  rstn_d[2] = 1'b0;
        default:          rstn_d    = 3'b111;
      endcase
    end
  end

  // Sticky error flags: set wins over clear
  always_comb begin
    err_bad_d = clear_errors ? 1'b0 : err_bad_q;
    err_ovr_d = clear_errors ? 1'b0 : err_ovr_q;
    err_to_d  = clear_errors ? 1'b0 : err_to_q;
    if (set_bad) err_bad_d = 1'b1;
    if (set_ovr) err_ovr_d = 1'b1;
    if (set_to)  err_to_d  = 1'b1;
  end

  // State and status registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      tgt_q      <= PROG_TGT_LUT;
      cnt_q      <= '0;
      timer_q    <= '0;
      started_q  <= 1'b0;
      rstn_q     <= 3'b111;
      pkt_done_q <= 1'b0;
      err_bad_q  <= 1'b0;
      err_ovr_q  <= 1'b0;
      err_to_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      tgt_q      <= tgt_d;
      cnt_q      <= cnt_d;
      timer_q    <= timer_d;
      started_q  <= started_d;
      rstn_q     <= rstn_d;
      pkt_done_q <= pkt_done_d;
      err_bad_q  <= err_bad_d;
      err_ovr_q  <= err_ovr_d;
      err_to_q   <= err_to_d;
    end
  end

  assign bus.prog_din_ready = din_ready;

  assign bus.lut_prog_din                = bus.prog_din[G_LUT_DWIDTH-1:0];
  assign bus.usr_fir_taps_prog_din       = bus.prog_din[G_TAP_DWIDTH-1:0];
  assign bus.reverb_taps_prog_din        = bus.prog_din[G_TAP_DWIDTH-1:0];
  assign bus.lut_prog_din_valid          = fwd_valid && (tgt_q == PROG_TGT_LUT);
  assign bus.usr_fir_taps_prog_din_valid = fwd_valid && (tgt_q == PROG_TGT_USR_FIR);
  assign bus.reverb_taps_prog_din_valid  = fwd_valid && (tgt_q == PROG_TGT_REVERB);

  assign lut_tf_sw_resetn  = rstn_q[0];
  assign usr_fir_sw_resetn = rstn_q[1];
  assign reverb_sw_resetn  = rstn_q[2];

  assign busy           = (state_q != IDLE);
  assign pkt_done       = pkt_done_q;
  assign err_bad_target = err_bad_q;
  assign err_overrun    = err_ovr_q;
  assign err_timeout    = err_to_q;

endmodule

// File: tb/tb_tulip_prog_sequencer.sv
// tb/tb_tulip_prog_sequencer.sv - directed self-checking bench for tulip_prog_sequencer
module tb_tulip_prog_sequencer;

  logic clk;
  logic reset;
  logic abort;
  logic clear_errors;
  logic lut_tf_sw_resetn, usr_fir_sw_resetn, reverb_sw_resetn;
  logic busy, pkt_done;
  logic err_bad_target, err_overrun, err_timeout;

  int total = 0;
  int bad   = 0;

  logic [31:0] q_lut[$];
  logic [31:0] q_fir[$];
  logic [31:0] q_rev[$];

  tulip_prog_sequencer_if #(.LUT_W(24), .TAP_W(16)) bus ();

  tulip_prog_sequencer #(
    .G_LUT_DWIDTH  (24),
    .G_TAP_DWIDTH  (16),
    .G_RESET_CYCLES(4),
    .G_DONE_TIMEOUT(1024)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .abort            (abort),
    .clear_errors     (clear_errors),
    .bus              (bus),
    .lut_tf_sw_resetn (lut_tf_sw_resetn),
    .usr_fir_sw_resetn(usr_fir_sw_resetn),
    .reverb_sw_resetn (reverb_sw_resetn),
    .busy             (busy),
    .pkt_done         (pkt_done),
    .err_bad_target   (err_bad_target),
    .err_overrun      (err_overrun),
    .err_timeout      (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every word each target accepts
  always @(posedge clk) begin
    if (bus.lut_prog_din_valid && bus.lut_prog_din_ready)
      q_lut.push_back(32'(bus.lut_prog_din));
    if (bus.usr_fir_taps_prog_din_valid && bus.usr_fir_taps_prog_din_ready)
      q_fir.push_back(32'(bus.usr_fir_taps_prog_din));
    if (bus.reverb_taps_prog_din_valid && bus.reverb_taps_prog_din_ready)
      q_rev.push_back(32'(bus.reverb_taps_prog_din));
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [2:0] valids();
    return {bus.reverb_taps_prog_din_valid, bus.usr_fir_taps_prog_din_valid, bus.lut_prog_din_valid};
  endfunction

  // Present a header at a negedge, let it be accepted, then sit out the 4 reset cycles
  task automatic send_hdr(input logic [31:0] h, input string tag);
    bus.prog_din       = h;
    bus.prog_din_valid = 1'b1;
    #1;
    chk({tag, "_hdr_ready"}, bus.prog_din_ready, 1);
    tick();
    bus.prog_din_valid = 1'b0;
    #1;
    chk({tag, "_busy_after_hdr"}, busy, 1);
    repeat (4) tick();
  endtask

  initial begin
    reset        = 1'b1;
    abort        = 1'b0;
    clear_errors = 1'b0;
    bus.prog_din = '0;
    bus.prog_din_valid = 1'b0;
    bus.lut_prog_din_ready = 1'b0;
    bus.lut_prog_din_done  = 1'b0;
    bus.usr_fir_taps_prog_din_ready = 1'b0;
    bus.usr_fir_taps_prog_din_done  = 1'b0;
    bus.reverb_taps_prog_din_ready  = 1'b0;
    bus.reverb_taps_prog_din_done   = 1'b0;

    repeat (2) tick();
    reset = 1'b0;
    #1;
    // Reset state
    chk("rst_ready_first", bus.prog_din_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valids", valids(), 0);
    chk("rst_resetn", {reverb_sw_resetn, usr_fir_sw_resetn, lut_tf_sw_resetn}, 3'b111);
    chk("rst_pkt_done", pkt_done, 0);
    chk("rst_errs", {err_bad_target, err_overrun, err_timeout}, 0);
    tick();
    #1;
    chk("idle_ready", bus.prog_din_ready, 1);

    // LUT packet: reset pulse width, word order, pkt_done
    bus.prog_din = 32'h0000_0003;
    bus.prog_din_valid = 1'b1;
    bus.lut_prog_din_ready = 1'b1;
    tick();
    bus.prog_din_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("lut_resetn_low", lut_tf_sw_resetn, 0);
      chk("lut_others_resetn", {reverb_sw_resetn, usr_fir_sw_resetn}, 2'b11);
      chk("lut_rst_ready", bus.prog_din_ready, 0);
      tick();
    end
    #1;
    chk("lut_resetn_high", lut_tf_sw_resetn, 1);
    for (int i = 1; i <= 3; i++) begin
      bus.prog_din = 32'(i);
      bus.prog_din_valid = 1'b1;
      #1;
      chk("lut_stream_valid", valids(), 3'b001);
      tick();
    end
    bus.prog_din_valid = 1'b0;
    bus.lut_prog_din_done = 1'b1;
    #1;
    chk("lut_wait_ready", bus.prog_din_ready, 0);
    chk("lut_wait_busy", busy, 1);
    tick();
    bus.lut_prog_din_done = 1'b0;
    #1;
    chk("lut_pkt_done", pkt_done, 1);
    chk("lut_busy_low", busy, 0);
    tick();
    #1;
    chk("lut_pkt_done_pulse", pkt_done, 0);
    chk("lut_words_n", q_lut.size(), 3);
    chk("lut_w0", q_lut[0], 32'h1);
    chk("lut_w1", q_lut[1], 32'h2);
    chk("lut_w2", q_lut[2], 32'h3);
    chk("lut_errs", {err_bad_target, err_overrun, err_timeout}, 0);

    // USR_FIR packet with target ready toggling 1-0-1
    send_hdr(32'h4000_0002, "fir");
    bus.usr_fir_taps_prog_din_ready = 1'b1;
    bus.prog_din = 32'h1234_AAAA;
    bus.prog_din_valid = 1'b1;
    #1;
    chk("fir_valids", valids(), 3'b010);
    chk("fir_ready1", bus.prog_din_ready, 1);
    tick();
    bus.prog_din = 32'h0000_BBBB;
    bus.usr_fir_taps_prog_din_ready = 1'b0;
    #1;
    chk("fir_ready0", bus.prog_din_ready, 0);
    tick();
    bus.usr_fir_taps_prog_din_ready = 1'b1;
    #1;
    chk("fir_ready1b", bus.prog_din_ready, 1);
    tick();
    bus.prog_din_valid = 1'b0;
    bus.usr_fir_taps_prog_din_done = 1'b1;
    tick();
    bus.usr_fir_taps_prog_din_done = 1'b0;
    #1;
    chk("fir_pkt_done", pkt_done, 1);
    chk("fir_words_n", q_fir.size(), 2);
    chk("fir_w0", q_fir[0], 32'hAAAA);
    chk("fir_w1", q_fir[1], 32'hBBBB);
    chk("fir_lut_rev_n", q_lut.size() + q_rev.size(), 3);

    // Invalid target: both words drained, flag sticky until cleared
    tick();
    bus.prog_din = 32'hC000_0002;
    bus.prog_din_valid = 1'b1;
    tick();
    bus.prog_din = 32'h0000_0055;
    #1;
    chk("bad_flag", err_bad_target, 1);
    for (int i = 0; i < 2; i++) begin
      chk("bad_drain_ready", bus.prog_din_ready, 1);
      chk("bad_drain_valids", valids(), 0);
      tick();
      #1;
    end
    bus.prog_din_valid = 1'b0;
    #1;
    chk("bad_idle", busy, 0);
    clear_errors = 1'b1;
    tick();
    clear_errors = 1'b0;
    #1;
    chk("bad_cleared", err_bad_target, 0);

    // Reverb overrun: done after word 2, remaining 3 drained
    send_hdr(32'h8000_0005, "rev");
    bus.reverb_taps_prog_din_ready = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      bus.prog_din = 32'h100 + 32'(i);
      bus.prog_din_valid = 1'b1;
      tick();
    end
    bus.reverb_taps_prog_din_done = 1'b1;
    bus.prog_din = 32'h103;
    #1;
    chk("ovr_valid_forced", bus.reverb_taps_prog_din_valid, 0);
    chk("ovr_ready_hold", bus.prog_din_ready, 0);
    tick();
    #1;
    chk("ovr_flag", err_overrun, 1);
    for (int i = 3; i <= 5; i++) begin
      bus.prog_din = 32'h100 + 32'(i);
      #1;
      chk("ovr_drain_valid", bus.reverb_taps_prog_din_valid, 0);
      chk("ovr_drain_ready", bus.prog_din_ready, 1);
      tick();
    end
    bus.prog_din_valid = 1'b0;
    bus.reverb_taps_prog_din_done = 1'b0;
    #1;
    chk("ovr_idle", busy, 0);
    chk("ovr_pkt_done", pkt_done, 0);
    chk("ovr_words_n", q_rev.size(), 2);
    chk("ovr_w1", q_rev[1], 32'h102);

    // Timeout: done never comes
    tick();
    send_hdr(32'h0000_0001, "to");
    bus.prog_din = 32'h0000_00AB;
    bus.prog_din_valid = 1'b1;
    tick();
    bus.prog_din_valid = 1'b0;
    repeat (1023) tick();
    #1;
    chk("to_not_yet", err_timeout, 0);
    chk("to_busy", busy, 1);
    tick();
    #1;
    chk("to_flag", err_timeout, 1);
    chk("to_idle", busy, 0);
    chk("to_pkt_done", pkt_done, 0);
    tick();
    send_hdr(32'h0000_0001, "after_to");
    bus.prog_din = 32'h0000_00CD;
    bus.prog_din_valid = 1'b1;
    tick();
    bus.prog_din_valid = 1'b0;
    bus.lut_prog_din_done = 1'b1;
    tick();
    bus.lut_prog_din_done = 1'b0;
    #1;
    chk("after_to_pkt_done", pkt_done, 1);
    chk("after_to_word", q_lut[q_lut.size()-1], 32'hCD);
    chk("after_to_sticky", err_timeout, 1);

    // Abort mid-STREAM
    clear_errors = 1'b1;
    tick();
    clear_errors = 1'b0;
    send_hdr(32'h0000_0003, "abt");
    bus.prog_din = 32'h11;
    bus.prog_din_valid = 1'b1;
    tick();
    abort = 1'b1;
    #1;
    chk("abt_valid0", valids(), 0);
    chk("abt_ready0", bus.prog_din_ready, 0);
    tick();
    abort = 1'b0;
    bus.prog_din_valid = 1'b0;
    #1;
    chk("abt_busy", busy, 0);
    chk("abt_resetn", {reverb_sw_resetn, usr_fir_sw_resetn, lut_tf_sw_resetn}, 3'b111);
    chk("abt_pkt_done", pkt_done, 0);
    chk("abt_errs", {err_bad_target, err_overrun, err_timeout}, 0);

    // Reset mid-RST
    bus.prog_din = 32'h4000_0001;
    bus.prog_din_valid = 1'b1;
    tick();
    bus.prog_din_valid = 1'b0;
    tick();
    #1;
    chk("mrst_in_rst", usr_fir_sw_resetn, 0);
    reset = 1'b1;
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_resetn", usr_fir_sw_resetn, 1);
    chk("mrst_valids", valids(), 0);
    chk("mrst_pkt_done", pkt_done, 0);
    tick();
    reset = 1'b0;
    tick();
    #1;
    chk("mrst_idle_ready", bus.prog_din_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tulip_prog_sequencer.md
# tulip_prog_sequencer

Sequences coefficient programming for the tulip_dsp datapath. It takes one 32-bit programming stream of header-framed packets and routes each payload to the target's programming port: LUT transfer function, user FIR taps or reverb taps. For each packet it holds that target's soft reset low, streams the payload, waits for the target's done, and reports status. It sits between the register/DMA front end and the tulip_dsp `*_prog_*` and `*_sw_resetn` inputs.

## Interface
- G_LUT_DWIDTH, 24: LUT programming word width.
- G_TAP_DWIDTH, 16: FIR/reverb tap width.
- G_RESET_CYCLES, 4: cycles target sw_resetn is held low per packet (≥1).
- G_DONE_TIMEOUT, 1024: max cycles waiting for target done after last word.
- clk  in  1  single clock; one clock domain; all logic on rising edge.
- reset  in  1  asynchronous, active-high.
- abort  in  1  synchronous abort of the current packet.
- clear_errors  in  1  clears sticky error flags.
- prog_din / _valid / _ready  in/in/out  32/1/1  header and payload stream.
- lut_prog_din / _valid / _ready / _done  out/out/in/in  G_LUT_DWIDTH/1/1/1
- usr_fir_taps_prog_din / _valid / _ready / _done  out/out/in/in  G_TAP_DWIDTH/1/1/1
- reverb_taps_prog_din / _valid / _ready / _done  out/out/in/in  G_TAP_DWIDTH/1/1/1
- lut_tf_sw_resetn, usr_fir_sw_resetn, reverb_sw_resetn  out  1  per-target soft resets.
- busy  out  1  high in every state except IDLE.
- pkt_done  out  1  one-cycle pulse when a packet completes without error.
- err_bad_target, err_overrun, err_timeout  out  1 each  sticky error flags.

## Operation
- Header word: [31:30] target (0 = LUT, 1 = USR_FIR, 2 = REVERB, 3 = invalid), [29:16] ignored, [15:0] payload count N. Payload word data is taken from bits [W-1:0], where W is the target's width.
- IDLE: prog_din_ready = 1. On header accept, latch target and N.
  - Target 3: set err_bad_target and go to DRAIN.
  - Otherwise go to RST.
- RST: selected sw_resetn = 0 for G_RESET_CYCLES cycles, then return it to 1.
  - If N = 0, go to WAIT_DONE; else go to STREAM.
- STREAM: combinational pass-through.
  - Selected target valid = prog_din_valid; prog_din_ready = selected target ready. Unselected valids = 0.
  - Decrement the remaining count per accepted word. After the Nth word, go to WAIT_DONE.
  - If selected done = 1 with words remaining: set err_overrun and go to DRAIN (target valid forced 0).
- WAIT_DONE: prog_din_ready = 0.
  - If selected done = 1: pulse pkt_done and go to IDLE.
  - If G_DONE_TIMEOUT cycles pass without done: set err_timeout and go to IDLE.
- DRAIN: prog_din_ready = 1. Discard remaining words; go to IDLE when the count reaches 0. A drain of 0 words returns to IDLE next cycle.
- abort (any state): next state IDLE, all target valids 0, all sw_resetn 1, counters cleared. No error is set and no pkt_done pulse is issued.
- clear_errors clears all three error flags. If an error sets in the same cycle, set wins.
- Flags are sticky and do not block further packets.

## Timing
- Reset values:
  - all *_valid = 0, prog_din_ready = 0 (first cycle after reset, then 1 in IDLE);
  - all sw_resetn = 1, busy = 0, pkt_done = 0, all errors = 0;
  - state = IDLE.
- Payload path has zero latency, purely combinational; throughput is 1 word/cycle when the target is ready.
- Header-accept to first payload accept is ≥ G_RESET_CYCLES+1 cycles.
- sw_resetn drives from a register, glitch-free.
- busy rises the cycle after header accept.
- pkt_done is asserted the cycle after done is sampled, together with busy = 0.
- Timeout counter starts at WAIT_DONE entry. The timeout fires on the cycle the count reaches G_DONE_TIMEOUT.
- If done and the last payload word arrive in the same cycle, the packet counts as success: enter WAIT_DONE and see done next cycle (done is level in targets).
- A valid dropped mid-stream by the source is allowed; the sequencer waits with no timeout in STREAM.

## Structure
- Shared package tulip_prog_pkg holds:
  - target enum (PROG_TGT_LUT/USR_FIR/REVERB/INVALID);
  - header field constants (TGT_MSB = 31, TGT_LSB = 30, LEN_MSB = 15);
  - state enum (IDLE, RST, STREAM, WAIT_DONE, DRAIN).
- Single module, no sub-module. The target demux and counters are small enough to inline.

## Test plan
- Header 0x0000_0003 then 3 LUT words 0x000001/2/3; stub done asserts after the 3rd -> lut_tf_sw_resetn low exactly 4 cycles, lut_prog_din sequence 1, 2, 3, pkt_done pulse, no errors.
- Header 0x4000_0002 with target ready toggling 1-0-1 -> usr_fir taps delivered in order with no loss or duplication; reverb and LUT valids stay 0.
- Header 0xC000_0002 plus 2 words -> err_bad_target = 1, both words consumed, no target valid, IDLE after; clear_errors -> 0.
- Header 0x8000_0005; stub done rises after word 2 -> err_overrun, remaining 3 words drained, reverb valid 0 from done onward.
- Header 0x0000_0001, done never asserted -> err_timeout exactly 1024 cycles after WAIT_DONE entry; next packet still processed.
- Assert abort mid-STREAM and separately assert reset mid-RST -> IDLE, all sw_resetn = 1, valids 0, busy 0, no pkt_done.
